// File: rtl/ysyx_24080006_csru_pkg.sv
// Shared types for the serialising CSR/system execution unit.
//   csr_op_t      : CSR file operation (read / write / set / clear)
//   csr_set_t     : {csr_enable, csr_op} bundle driven into the CSR file
//   csru_kind_e   : micro-op class accepted from dispatch
//   csru_state_e  : sequencing states of the unit
//   CSR_*         : machine-mode CSR addresses used by the unit and its bench
package ysyx_24080006_csru_pkg;

   typedef enum logic [1:0] {
      CSR_READ  = 2'd0,
      CSR_WRITE = 2'd1,
      CSR_SET   = 2'd2,
      CSR_CLEAR = 2'd3
   } csr_op_t;

   typedef struct packed {
      logic    csr_enable;
      csr_op_t csr_op;
   } csr_set_t;

   typedef enum logic [1:0] {
      CSRU_CSR   = 2'd0,
      CSRU_ECALL = 2'd1,
      CSRU_MRET  = 2'd2
   } csru_kind_e;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_HEAD = 2'd1,
      EXEC      = 2'd2,
      WB        = 2'd3
   } csru_state_e;

   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MCYCLE   = 12'hB00;

endpackage

// File: rtl/ysyx_24080006_csru_if.sv
// Dispatch-side and writeback-side handshake bundle of the CSR unit.
//   in_*  : micro-op offered by dispatch (valid/ready)
//   wb_*  : result returned to commit/flush logic (valid/ready)
// master = dispatch/commit side, slave = CSR unit.
interface ysyx_24080006_csru_if
   import ysyx_24080006_csru_pkg::*;
#(
   parameter int ROB_W = 4
) ();

   logic             in_valid;
   logic             in_ready;
   csru_kind_e       in_kind;
   csr_op_t          in_op;
   logic [11:0]      in_csr_name;
   logic [31:0]      in_wdata;
   logic [31:0]      in_pc;
   logic [ROB_W-1:0] in_rob_idx;

   logic             wb_valid;
   logic             wb_ready;
   logic [ROB_W-1:0] wb_rob_idx;
   logic [31:0]      wb_data;
   logic             wb_redirect;
   logic [31:0]      wb_target;

   modport master (
      output in_valid, in_kind, in_op, in_csr_name, in_wdata, in_pc, in_rob_idx,
      input  in_ready,
      input  wb_valid, wb_rob_idx, wb_data, wb_redirect, wb_target,
      output wb_ready
   );

   modport slave (
      input  in_valid, in_kind, in_op, in_csr_name, in_wdata, in_pc, in_rob_idx,
      output in_ready,
      output wb_valid, wb_rob_idx, wb_data, wb_redirect, wb_target,
      input  wb_ready
   );

endinterface

// File: rtl/ysyx_24080006_csru.sv
// Serialising CSR / ECALL / MRET execution unit.
// Holds one micro-op until it is the ROB head, drives the CSR file for a
// single cycle, then returns the old CSR value and a redirect target.
// Ports:
//   clock, reset           : clock, async active-low reset
//   io (slave)             : dispatch accept and writeback handshakes
//   rob_head_valid/idx     : current ROB head
//   flush                  : squash of speculative state
//   csr_set/name/wdata/pc  : command to the CSR file
//   ecall, mret            : one-cycle trap entry / trap return strobes
//   csr_rdata              : combinational read data from the CSR file
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | no op held, in_ready=1
// WAIT_HEAD | op latched, waiting for its tag at ROB head
// EXEC      | one cycle driving the CSR file, result captured
// WB        | result presented until wb_ready
module ysyx_24080006_csru
   import ysyx_24080006_csru_pkg::*;
#(
   parameter int ROB_DEPTH = 16,
   parameter int ROB_W     = $clog2(ROB_DEPTH)
) (
   input  logic                 clock,
   input  logic                 reset,
   ysyx_24080006_csru_if.slave  io,
   input  logic                 rob_head_valid,
   input  logic [ROB_W-1:0]     rob_head_idx,
   input  logic                 flush,
   output csr_set_t             csr_set,
   output logic [11:0]          csr_name,
   output logic [31:0]          csr_wdata,
   output logic [31:0]          csr_pc,
   output logic                 ecall,
   output logic                 mret,
   input  logic [31:0]          csr_rdata
);

   csru_state_e      state_q, state_d;

   csru_kind_e       kind_q;
   csr_op_t          op_q;
   logic [11:0]      name_q;
   logic [31:0]      wdata_q;
   logic [31:0]      pc_q;
   logic [ROB_W-1:0] tag_q;

   logic [31:0]      wb_data_q;
   logic [31:0]      wb_target_q;
   logic             wb_redirect_q;

   logic             accept;
   logic             head_hit;

   // A flush in the accept cycle wins over in_valid: the offered op is younger
   // than whatever caused the flush.
   assign accept   = (state_q == IDLE) && io.in_valid && !flush;
   assign head_hit = rob_head_valid && (rob_head_idx == tag_q);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (accept) state_d = WAIT_HEAD;
         WAIT_HEAD: begin
            if (flush)         state_d = IDLE;
            else if (head_hit) state_d = EXEC;
         end
         // Once at ROB head the op is committed, so flush no longer applies.
         EXEC:      state_d = WB;
         WB:        if (io.wb_ready) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         kind_q  <= CSRU_CSR;
         op_q    <= CSR_READ;
         name_q  <= '0;
         wdata_q <= '0;
         pc_q    <= '0;
         tag_q   <= '0;
      end else if (accept) begin
         kind_q  <= io.in_kind;
         op_q    <= io.in_op;
         name_q  <= io.in_csr_name;
         wdata_q <= io.in_wdata;
         pc_q    <= io.in_pc;
         tag_q   <= io.in_rob_idx;
      end
   end

   // csr_rdata is the pre-write value during EXEC; for ECALL/MRET it is the
   // mtvec/mepc contents selected below and becomes the refetch target.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wb_data_q     <= '0;
         wb_target_q   <= '0;
         wb_redirect_q <= 1'b0;
      end else if (state_q == EXEC) begin
         if (kind_q == CSRU_CSR) begin
            wb_data_q     <= csr_rdata;
            wb_target_q   <= pc_q + 32'd4;
            wb_redirect_q <= (op_q != CSR_READ);
         end else begin
            wb_data_q     <= '0;
            wb_target_q   <= csr_rdata;
            wb_redirect_q <= 1'b1;
         end
      end
   end

   always_comb begin
      csr_set.csr_enable = 1'b0;
      csr_set.csr_op     = op_q;
      csr_name           = '0;
      ecall              = 1'b0;
      mret               = 1'b0;
      if (state_q == EXEC) begin
         case (kind_q)
            CSRU_CSR: begin
               csr_set.csr_enable = 1'b1;
               csr_name           = name_q;
            end
            CSRU_ECALL: begin
               ecall    = 1'b1;
               csr_name = CSR_MTVEC;
            end
            CSRU_MRET: begin
               mret     = 1'b1;
               csr_name = CSR_MEPC;
            end
            default: ;
         endcase
      end
   end

   assign csr_wdata = wdata_q;
   assign csr_pc    = pc_q;

   assign io.in_ready    = (state_q == IDLE);
   assign io.wb_valid    = (state_q == WB);
   assign io.wb_rob_idx  = tag_q;
   assign io.wb_data     = wb_data_q;
   assign io.wb_redirect = wb_redirect_q;
   assign io.wb_target   = wb_target_q;

endmodule

// File: doc/ysyx_24080006_csru.md
Name: ysyx_24080006_csru

Overview:
Serialising CSR/system execution unit in the OoO backend, directly upstream of the CSR register file. Accepts one CSR, ECALL or MRET micro-op from dispatch and holds it until it reaches ROB head. It then drives the CSR file's csr_set/csr_name/csr_wdata/csr_pc/ecall/mret inputs for exactly one cycle. Finally it writes back the old CSR value plus a redirect target (mtvec, mepc or pc+4) to the commit/flush logic.

Parameters:
ROB_DEPTH, 16, ROB entries; ROB_W = $clog2(ROB_DEPTH).

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
in_valid  in  1  dispatch offers micro-op
in_ready  out  1  unit idle, can accept
in_kind  in  csru_kind_e  CSRU_CSR / CSRU_ECALL / CSRU_MRET
in_op  in  csr_op_t  CSR_READ/WRITE/SET/CLEAR (CSRU_CSR only)
in_csr_name  in  12  CSR address
in_wdata  in  32  rs1 value or zero-extended zimm
in_pc  in  32  instruction PC
in_rob_idx  in  ROB_W  ROB tag
rob_head_valid  in  1  ROB head entry valid
rob_head_idx  in  ROB_W  ROB head tag
flush  in  1  squash all speculative state
csr_set  out  csr_set_t  {csr_enable, csr_op} to CSR file
csr_name  out  12  CSR address to CSR file
csr_wdata  out  32  write operand to CSR file
csr_pc  out  32  trap PC to CSR file
ecall  out  1  take environment-call trap
mret  out  1  return from trap
csr_rdata  in  32  combinational read data from CSR file
wb_valid  out  1  result available
wb_ready  in  1  commit consumes result
wb_rob_idx  out  ROB_W  tag of result
wb_data  out  32  old CSR value (0 for ECALL/MRET)
wb_redirect  out  1  flush younger ops and refetch
wb_target  out  32  refetch PC

Behaviour:
- States: IDLE, WAIT_HEAD, EXEC, WB. Reset state is IDLE. Reset values: wb_valid=0, ecall=0, mret=0, csr_set.csr_enable=0, all latched fields 0. in_ready=1 when reset is deasserted and the unit is in IDLE.
- IDLE: in_ready=1. If in_valid, latch kind/op/name/wdata/pc/rob_idx and go to WAIT_HEAD. Only one op is in flight.
- WAIT_HEAD: if rob_head_valid and rob_head_idx==latched tag, go to EXEC next cycle. The head match is checked the cycle after accept at the earliest.
- EXEC (exactly 1 cycle, all CSR-file outputs combinational from state):
  - CSRU_CSR: csr_enable=1, csr_op=op, csr_name=name, csr_wdata=wdata. Capture csr_rdata (pre-write value) into wb_data. redirect=1 only if op≠CSR_READ; target=pc+4.
  - CSRU_ECALL: ecall=1, csr_pc=pc, csr_name=CSR_MTVEC, csr_enable=0. Capture csr_rdata as target, redirect=1, wb_data=0.
  - CSRU_MRET: mret=1, csr_name=CSR_MEPC, csr_enable=0. Capture csr_rdata as target, redirect=1, wb_data=0.
  - Then go to WB.
- Outside EXEC: ecall=mret=0, csr_enable=0, csr_name=0.
- WB: wb_valid=1; fields are stable until wb_ready. On wb_valid&wb_ready, go to IDLE. in_ready stays 0 in the handshake cycle.
- flush in IDLE or WAIT_HEAD: drop the latched op and go to IDLE. A new in_valid in the same cycle as flush is ignored.
- flush in EXEC or WB: ignored. The op is at ROB head and is architecturally committed.
- Target arithmetic: pc+4 is 32-bit and wraps at 0xFFFF_FFFC→0x0000_0000.

Decomposition:
- OoO_pkg gains csru_kind_e (2-bit enum: CSRU_CSR, CSRU_ECALL, CSRU_MRET) and csru_state_e (IDLE, WAIT_HEAD, EXEC, WB).
- Reuses the existing csr_op_t, csr_set_t and riscv_instr CSR address constants.
- No sub-module; a single FSM plus a latch register bank.

Test Plan:
- Reset: hold reset=0 mid-WB → in_ready=1, wb_valid=0, ecall=0 immediately (asynchronous), state IDLE after release.
- CSRRW: name=CSR_MTVEC, wdata=0x8000_0100, tag 5, head=5 two cycles later → exactly one cycle with csr_enable=1, op=CSR_WRITE. wb_data=old mtvec (0). wb_redirect=1, wb_target=pc+4. A subsequent read returns 0x8000_0100.
- ECALL: pc=0x8000_0040, mtvec=0x8000_0100 → one-cycle ecall=1 with csr_pc=0x8000_0040. wb_target=0x8000_0100, wb_redirect=1. The CSR file then shows mcause=11 and mepc=0x8000_0040.
- MRET: mepc=0x8000_0044 → one-cycle mret=1, wb_target=0x8000_0044, wb_data=0.
- Flush in WAIT_HEAD: flush while head≠tag → IDLE next cycle, no csr_enable/ecall pulse ever. Flush asserted in WB → wb_valid is held until wb_ready.
- Back-pressure: wb_ready=0 for 4 cycles → wb fields are stable and in_ready=0 throughout. The CSRR of mcycle captures the value from the EXEC cycle, not the WB release cycle.
